// File: rtl/seq_alu.sv
// seq_alu: handshaked, registered ALU with iterative unsigned multiply and restoring divide
//   clk, reset                                   : clock, synchronous active-high reset
//   in_valid_i, in_ready_o, op_i, a_i, b_i, cin_i : request channel
//   out_valid_o, out_ready_i                      : result handshake
//   result_o, result_hi_o, cout_o, zero_o, eq_o, err_o : registered result fields
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             cout_o,
  output logic             zero_o,
  output logic             eq_o,
  output logic             err_o
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             mul_q;
  logic [WIDTH-1:0] opnd_q, hi_q, lo_q, hi_d, lo_d, alu_res;
  logic             cout_q, zero_q, eq_q, err_q, alu_cout, alu_err;
  logic [WIDTH:0]   sum, dif, msum, shd, dd;
  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    dif = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin_i};
    alu_res = '0;
    alu_cout = 1'b0;
    alu_err = 1'b0;
    case (op_i)
      4'd0: {alu_cout, alu_res} = sum;
      4'd1: {alu_cout, alu_res} = dif;
      4'd2: alu_res = a_i & b_i;
      4'd3: alu_res = a_i | b_i;
      4'd4: alu_res = ~a_i;
      4'd5: alu_res = ~a_i + WIDTH'(1);
      4'd6: alu_res = {a_i[WIDTH-2:0], 1'b0};
      4'd7: alu_res = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
      4'd8: alu_res = a_i;
      4'd9: alu_res = {b_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'd10, 4'd11: alu_err = op_i[0] && b_i == '0;
      default: {alu_cout, alu_err} = 2'b11;
    endcase
  end
  // hi/lo form one double-width shift register: product for MUL, remainder/quotient for DIVU.
  // A zero divisor never borrows, so the quotient fills with ones and the remainder ends as a.
  always_comb begin
    msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shd = {hi_q, lo_q[WIDTH-1]};
    dd = shd - {1'b0, opnd_q};
    {hi_d, lo_d} = mul_q ? {msum, lo_q[WIDTH-1:1]}
                 : dd[WIDTH] ? {shd[WIDTH-1:0], lo_q[WIDTH-2:0], 1'b0}
                 : {dd[WIDTH-1:0], lo_q[WIDTH-2:0], 1'b1};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mul_q <= 1'b0;
      opnd_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
      eq_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          eq_q <= a_i == b_i;
          err_q <= alu_err;
          cout_q <= alu_cout;
          mul_q <= op_i == 4'd10;
          opnd_q <= op_i == 4'd10 ? a_i : b_i;
          cnt_q <= CW'(WIDTH);
          hi_q <= '0;
          if (op_i == 4'd10 || op_i == 4'd11) begin
            state_q <= BUSY;
            lo_q <= op_i == 4'd10 ? b_i : a_i;
            zero_q <= 1'b0;
          end else begin
            state_q <= DONE;
            lo_q <= alu_res;
            zero_q <= alu_res == '0;
          end
        end
        BUSY: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            zero_q <= lo_d == '0;
          end
        end
        DONE: if (out_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready_o = state_q == IDLE;
  assign out_valid_o = state_q == DONE;
  assign result_o = lo_q;
  assign result_hi_o = hi_q;
  assign cout_o = cout_q;
  assign zero_o = zero_q;
  assign eq_o = eq_q;
  assign err_o = err_q;
endmodule
